// File: rtl/sd_pkg.sv
// Shared definitions for the sigma-delta reading averager.
package sd_pkg;

    localparam int unsigned SD_SAMPLE_W = 33;

    localparam int unsigned AVG_LOG2_DEFAULT = 4;
    localparam logic signed [SD_SAMPLE_W-1:0] OL_LIMIT_DEFAULT = 33'sd1200000000;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } sd_state_e;

endpackage

// File: rtl/sd_reading_avg_if.sv
// Sample-in / averaged-result-out signal bundle for sd_reading_avg.
interface sd_reading_avg_if;
    import sd_pkg::*;

    logic signed [SD_SAMPLE_W-1:0] sample_in;
    logic                          sample_valid;
    logic                          hold;
    logic                          restart;
    logic                          clear_overrun;
    logic signed [SD_SAMPLE_W-1:0] avg_out;
    logic                          avg_overload;
    logic                          avg_valid;
    logic                          avg_ready;
    logic                          overrun;

    modport master (
        output sample_in, sample_valid, hold, restart, clear_overrun, avg_ready,
        input  avg_out, avg_overload, avg_valid, overrun
    );

    modport slave (
        input  sample_in, sample_valid, hold, restart, clear_overrun, avg_ready,
        output avg_out, avg_overload, avg_valid, overrun
    );

endinterface

// File: rtl/sd_round_shift.sv
// Block sum -> rounded (half up) average, arithmetic shift by AVG_LOG2, truncated to sample width.
module sd_round_shift
    import sd_pkg::*;
#(
    parameter int unsigned AVG_LOG2 = AVG_LOG2_DEFAULT
) (
    input  logic signed [SD_SAMPLE_W+AVG_LOG2-1:0] acc,
    output logic signed [SD_SAMPLE_W-1:0]          result
);

    localparam int unsigned ACC_W = SD_SAMPLE_W + AVG_LOG2;

    if (AVG_LOG2 == 0) begin : g_pass
        assign result = acc;
    end else begin : g_round
        localparam logic signed [ACC_W:0] HALF = (ACC_W + 1)'(1) <<< (AVG_LOG2 - 1);
        // One guard bit so the rounding bias cannot wrap a full-scale positive sum.
        logic signed [ACC_W:0] biased;
        assign biased = (ACC_W + 1)'(acc) + HALF;
        assign result = SD_SAMPLE_W'(biased >>> AVG_LOG2);
    end

endmodule

// File: rtl/sd_reading_avg.sv
// Block averager: sums 2^AVG_LOG2 accepted samples, emits a rounded average through a
// single-entry valid/ready output register with a sticky overrun flag.
module sd_reading_avg
    import sd_pkg::*;
#(
    parameter int unsigned                    AVG_LOG2 = AVG_LOG2_DEFAULT,
    parameter logic signed [SD_SAMPLE_W-1:0]  OL_LIMIT = OL_LIMIT_DEFAULT
) (
    input logic             clk,
    input logic             reset,
    sd_reading_avg_if.slave bus
);

    localparam int unsigned ACC_W = SD_SAMPLE_W + AVG_LOG2;
    localparam int unsigned CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] N_CNT = CNT_W'(1 << AVG_LOG2);

    sd_state_e                     state_q, state_d;
    logic signed [ACC_W-1:0]       acc_q, acc_d, sample_ext;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          accept;
    logic signed [SD_SAMPLE_W-1:0] result;
    logic                          overload;
    logic                          done, handshake, load, drop;

    assign accept     = bus.sample_valid & ~bus.hold & ~bus.restart;
    assign sample_ext = ACC_W'(bus.sample_in);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (bus.restart) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                // IDLE holds acc=0/count=0, so it shares the accumulate path with ACCUM.
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc_d   = acc_q + sample_ext;
                        cnt_d   = cnt_q + 1'b1;
                        state_d = (cnt_d == N_CNT) ? DONE : ACCUM;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    if (accept) begin
                        acc_d   = sample_ext;
                        cnt_d   = CNT_W'(1);
                        state_d = (N_CNT == CNT_W'(1)) ? DONE : ACCUM;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    sd_round_shift #(
        .AVG_LOG2(AVG_LOG2)
    ) u_round_shift (
        .acc   (acc_q),
        .result(result)
    );

    assign overload  = (result > OL_LIMIT) || (result < -OL_LIMIT);
    assign done      = (state_q == DONE);
    assign handshake = bus.avg_valid & bus.avg_ready;
    assign load      = done & (~bus.avg_valid | handshake);
    assign drop      = done & ~load;

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.avg_out      <= '0;
            bus.avg_overload <= 1'b0;
            bus.avg_valid    <= 1'b0;
            bus.overrun      <= 1'b0;
        end else begin
            if (load) begin
                bus.avg_out      <= result;
                bus.avg_overload <= overload;
                bus.avg_valid    <= 1'b1;
            end else if (handshake) begin
                bus.avg_valid <= 1'b0;
            end
            bus.overrun <= drop | (bus.overrun & ~bus.clear_overrun);
        end
    end

endmodule

// File: tb/tb_sd_reading_avg.sv
// Self-checking bench for sd_reading_avg (AVG_LOG2=2, OL_LIMIT=1000): directed cases plus random.
module tb_sd_reading_avg;

    localparam int unsigned N     = 4;
    localparam longint      LIMIT = 1000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sd_reading_avg_if bus ();

    sd_reading_avg #(
        .AVG_LOG2(2),
        .OL_LIMIT(33'sd1000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int    n_vec  = 0;
    int    n_fail = 0;
    string phase  = "init";

    // Reference model: list of samples in the current block, one result in flight, output slot.
    longint blk[$];
    bit     pend_v;
    longint pend;
    bit     m_valid;
    longint m_out;
    bit     m_ovl;
    bit     m_ovr;

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d expected %0d", phase, tag, got, exp);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic void model_edge(input bit v, input longint s, input bit h, input bit r,
                                       input bit c, input bit rdy, input bit rs);
        longint sum;
        bit     dropped;
        if (rs) begin
            blk.delete();
            pend_v  = 0;
            m_valid = 0;
            m_out   = 0;
            m_ovl   = 0;
            m_ovr   = 0;
            return;
        end
        dropped = 0;
        if (pend_v) begin
            if (!m_valid || rdy) begin
                m_valid = 1;
                m_out   = pend;
                m_ovl   = (pend > LIMIT) || (pend < -LIMIT);
            end else begin
                dropped = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        m_ovr  = dropped || (m_ovr && !c);
        pend_v = 0;
        if (r) begin
            blk.delete();
        end else if (v && !h) begin
            blk.push_back(s);
            if (blk.size() == N) begin
                sum = 0;
                foreach (blk[i]) sum += blk[i];
                pend   = floor_div(sum + N / 2, N);
                pend_v = 1;
                blk.delete();
            end
        end
    endfunction

    task automatic cyc(input bit v, input longint s, input bit h, input bit r, input bit c,
                       input bit rdy, input bit rs);
        logic [32:0] s33;
        s33 = s[32:0];
        @(negedge clk);
        bus.sample_valid  = v;
        bus.sample_in     = s33;
        bus.hold          = h;
        bus.restart       = r;
        bus.clear_overrun = c;
        bus.avg_ready     = rdy;
        reset             = rs;
        @(posedge clk);
        model_edge(v, s, h, r, c, rdy, rs);
        #1;
        check("valid", longint'(bus.avg_valid), longint'(m_valid));
        if (m_valid) begin
            check("out", longint'(bus.avg_out), m_out);
            check("ovl", longint'(bus.avg_overload), longint'(m_ovl));
        end else if (rs) begin
            check("out_rst", longint'(bus.avg_out), 0);
            check("ovl_rst", longint'(bus.avg_overload), 0);
        end
        check("overrun", longint'(bus.overrun), longint'(m_ovr));
    endtask

    task automatic sample(input longint s);
        cyc(1, s, 0, 0, 0, 1, 0);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, rdy, 0);
    endtask

    task automatic block4(input longint a, input longint b, input longint c, input longint d);
        sample(a);
        sample(b);
        sample(c);
        sample(d);
    endtask

    initial begin
        longint s;
        bit     v, h, r, c, rdy, rs;

        phase = "reset";
        cyc(0, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 1, 1);
        idle(2, 1);

        phase = "basic";
        block4(10, 11, 12, 13);
        idle(4, 1);

        phase = "neg_round";
        block4(-5, -5, -5, -6);
        idle(3, 1);
        phase = "overload_pos";
        block4(1001, 1001, 1001, 1001);
        idle(3, 1);
        phase = "overload_edge";
        block4(-1000, -1000, -1000, -1000);
        idle(3, 1);

        phase = "overrun";
        for (int i = 0; i < 4; i++) cyc(1, 4, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 8, 0, 0, 0, 0, 0);
        idle(4, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        idle(2, 1);
        cyc(0, 0, 0, 0, 1, 1, 0);
        idle(2, 1);

        phase = "restart";
        sample(100);
        sample(100);
        cyc(0, 0, 0, 1, 0, 1, 0);
        block4(4, 4, 4, 4);
        idle(3, 1);
        phase = "restart_sample";
        sample(20);
        cyc(1, 500, 0, 1, 0, 1, 0);
        block4(6, 6, 6, 6);
        idle(3, 1);

        phase = "hold";
        sample(3);
        sample(5);
        cyc(1, 999, 1, 0, 0, 1, 0);
        cyc(0, 999, 1, 0, 0, 1, 0);
        cyc(1, -999, 1, 0, 0, 1, 0);
        sample(7);
        sample(9);
        idle(3, 1);

        phase = "reset_mid";
        sample(1);
        sample(2);
        cyc(0, 0, 0, 0, 0, 1, 1);
        block4(30, 30, 30, 30);
        idle(3, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        block4(7, 7, 7, 7);
        idle(3, 1);

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            v   = ($urandom_range(0, 99) < 70);
            h   = ($urandom_range(0, 99) < 10);
            r   = ($urandom_range(0, 99) < 3);
            c   = ($urandom_range(0, 99) < 5);
            rdy = ($urandom_range(0, 99) < 60);
            rs  = ($urandom_range(0, 999) < 5);
            if ($urandom_range(0, 3) == 0) s = longint'($signed($urandom)) * 2 + $urandom_range(0, 1);
            else s = longint'($urandom_range(0, 2400)) - 1200;
            cyc(v, s, h, r, c, rdy, rs);
        end
        idle(4, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
